// File: rtl/pc_irq_injector_pkg.sv
// Shared definitions for the PC-triggered interrupt injector.
// Holds the register map offsets (addr[3:2]), the CTRL and STATUS bit
// positions, and the FSM state encoding.
package pc_irq_injector_pkg;

    // Register offsets, word index taken from addr[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_TARGET = 2'd1;
    localparam logic [1:0] REG_HOLD   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bits
    localparam int CTRL_EN    = 0;
    localparam int CTRL_REARM = 1;

    // STATUS bits
    localparam int STAT_FIRED = 0;
    localparam int STAT_BUSY  = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_ASSERT = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/pc_irq_injector_if.sv
// Bridge-side register bus for the PC interrupt injector.
//   we   : write strobe, already qualified by the bridge for this device
//   addr : byte address, only addr[3:2] is decoded by the device
//   din  : write data
//   dout : read data, combinational from addr[3:2]
// master = bridge side, slave = device side.
interface pc_irq_injector_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output we, addr, din, input dout);
    modport slave  (input we, addr, din, output dout);
endinterface

// File: rtl/pc_irq_injector.sv
// PC-triggered interrupt source. When armed and the commit-point PC equals
// TARGET, irq is raised for HOLD+1 cycles. With REARM set, one low GAP
// cycle follows and the block re-arms; otherwise it parks in DONE until
// CTRL is rewritten.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   pc    : macroscopic PC at the commit point
//   bus   : register bus (slave modport)
//   irq   : registered interrupt request to the CPU
module pc_irq_injector
    import pc_irq_injector_pkg::*;
#(
    parameter int HOLD_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    pc_irq_injector_if.slave bus,
    output logic             irq
);

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] cnt, cnt_nxt;
    logic [HOLD_W-1:0] hold_q;
    logic [31:0]       target_q;
    logic              en_q, rearm_q, fired_q;
    logic              irq_nxt, fire, busy;
    logic [1:0]        off;
    logic              wr_ctrl, wr_target, wr_hold, wr_status;
    logic              unused_addr;

    assign off       = bus.addr[3:2];
    assign wr_ctrl   = bus.we && (off == REG_CTRL);
    assign wr_target = bus.we && (off == REG_TARGET);
    assign wr_hold   = bus.we && (off == REG_HOLD);
    assign wr_status = bus.we && (off == REG_STATUS);
    assign busy      = (state == ST_ASSERT) || (state == ST_GAP);

    // Device range decode happens in the bridge; the remaining address bits are don't-care.
    assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

    // Register file
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q     <= 1'b0;
            rearm_q  <= 1'b0;
            target_q <= '0;
            hold_q   <= '0;
            fired_q  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_q    <= bus.din[CTRL_EN];
                rearm_q <= bus.din[CTRL_REARM];
            end
            if (wr_target) target_q <= bus.din;
            if (wr_hold)   hold_q   <= bus.din[HOLD_W-1:0];
            // A trigger on the same edge as a STATUS write keeps FIRED set.
            if (fire)           fired_q <= 1'b1;
            else if (wr_status) fired_q <= 1'b0;
        end
    end

    always_comb begin
        bus.dout = '0;
        case (off)
            REG_CTRL:   begin
                bus.dout[CTRL_EN]    = en_q;
                bus.dout[CTRL_REARM] = rearm_q;
            end
            REG_TARGET: bus.dout = target_q;
            REG_HOLD:   bus.dout = 32'(hold_q);
            REG_STATUS: begin
                bus.dout[STAT_FIRED] = fired_q;
                bus.dout[STAT_BUSY]  = busy;
            end
            default:    bus.dout = '0;
        endcase
    end

    // FSM state, hold counter and registered irq
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            irq   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            irq   <= irq_nxt;
        end
    end

    // irq_nxt is the value irq takes on this edge, so the match edge itself
    // raises irq and the count-to-zero edge drops it: HOLD+1 high cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        irq_nxt   = 1'b0;
        fire      = 1'b0;
        if (wr_ctrl) begin
            // A CTRL write restarts the block and swallows any same-cycle match.
            state_nxt = bus.din[CTRL_EN] ? ST_ARMED : ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE:   if (en_q) state_nxt = ST_ARMED;
                ST_ARMED:  if (pc == target_q) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = hold_q;
                    irq_nxt   = 1'b1;
                    fire      = 1'b1;
                end
                ST_ASSERT: if (cnt == '0) begin
                    state_nxt = rearm_q ? ST_GAP : ST_DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    irq_nxt = 1'b1;
                end
                ST_GAP:    state_nxt = ST_ARMED;
                ST_DONE:   state_nxt = ST_DONE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_irq_injector.sv
// Self-checking bench for pc_irq_injector. The reference model tracks the
// injector as time windows (cycle index of the last high cycle, the gap
// cycle, and the first cycle a match may fire) rather than as states.
module tb_pc_irq_injector;

    localparam logic [31:0] A_CTRL = 32'h0;
    localparam logic [31:0] A_TGT  = 32'h4;
    localparam logic [31:0] A_HOLD = 32'h8;
    localparam logic [31:0] A_STAT = 32'hC;
    localparam longint NEVER = 64'h0FFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        irq;

    pc_irq_injector_if bus_if();

    pc_irq_injector #(.HOLD_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .pc    (pc),
        .bus   (bus_if.slave),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    longint      m_c          = 0;
    longint      m_arm_from   = NEVER;
    longint      m_high_until = -1;
    longint      m_gap_at     = -1;
    logic        m_en = 0, m_rearm = 0, m_fired = 0;
    logic [31:0] m_target = 0;
    logic [7:0]  m_hold = 0;

    function automatic logic exp_irq();
        return m_c <= m_high_until;
    endfunction

    function automatic logic [31:0] exp_dout(input logic [1:0] o);
        logic busy;
        busy = (m_c <= m_high_until) || (m_c == m_gap_at);
        case (o)
            2'd0:    return {30'd0, m_rearm, m_en};
            2'd1:    return m_target;
            2'd2:    return {24'd0, m_hold};
            default: return {30'd0, busy, m_fired};
        endcase
    endfunction

    task automatic model_edge();
        logic [1:0] o;
        logic       trig;
        o = bus_if.addr[3:2];
        trig = 1'b0;
        m_c++;
        if (reset) begin
            m_en = 0; m_rearm = 0; m_fired = 0; m_target = 0; m_hold = 0;
            m_arm_from = NEVER; m_high_until = -1; m_gap_at = -1;
        end else begin
            if (bus_if.we && o == 2'd0) begin
                m_arm_from   = bus_if.din[0] ? m_c + 1 : NEVER;
                m_high_until = -1;
                m_gap_at     = -1;
            end else if (m_c >= m_arm_from && pc == m_target) begin
                trig = 1'b1;
                m_high_until = m_c + m_hold;
                if (m_rearm) begin
                    m_gap_at   = m_c + m_hold + 1;
                    m_arm_from = m_c + m_hold + 3;
                end else begin
                    m_gap_at   = -1;
                    m_arm_from = NEVER;
                end
            end
            if (bus_if.we) begin
                case (o)
                    2'd0: begin m_en = bus_if.din[0]; m_rearm = bus_if.din[1]; end
                    2'd1: m_target = bus_if.din;
                    2'd2: m_hold = bus_if.din[7:0];
                    default: m_fired = 1'b0;
                endcase
            end
            if (trig) m_fired = 1'b1;
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle.
    task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] p);
        bus_if.we = w; bus_if.addr = a; bus_if.din = d; pc = p;
        @(posedge clk);
        model_edge();
        #1;
        bus_if.we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(0, A_CTRL, 0, 0);
        cyc(0, A_CTRL, 0, 0);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end
        for (int o = 0; o < 4; o++) begin
            bus_if.addr = 32'(o) << 2;
            #1;
            n_tests++;
            if (bus_if.dout !== 32'h0) begin
                n_fail++; $display("FAIL reset_reg%0d got %h exp 0", o, bus_if.dout);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single_shot();
        int highs;
        cyc(1, A_STAT, 0, 0);
        cyc(1, A_TGT, 32'h4198, 0);
        cyc(1, A_HOLD, 5, 0);
        cyc(1, A_CTRL, 1, 0);
        cyc(0, A_STAT, 0, 32'h4198);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL single_first got %b exp 1", irq); end
        n_tests++;
        if (bus_if.dout !== 32'h3) begin n_fail++; $display("FAIL single_stat_busy got %h exp 3", bus_if.dout); end
        highs = 1;
        for (int i = 0; i < 10; i++) begin
            cyc(0, A_STAT, 0, 0);
            n_tests++;
            if (irq !== exp_irq()) begin n_fail++; $display("FAIL single_irq i%0d got %b exp %b", i, irq, exp_irq()); end
            n_tests++;
            if (bus_if.dout !== exp_dout(2'd3)) begin
                n_fail++; $display("FAIL single_stat i%0d got %h exp %h", i, bus_if.dout, exp_dout(2'd3));
            end
            if (irq) highs++;
        end
        n_tests++;
        if (highs !== 6) begin n_fail++; $display("FAIL single_len got %0d exp 6", highs); end
        n_tests++;
        if (bus_if.dout !== 32'h1) begin n_fail++; $display("FAIL single_stat_end got %h exp 1", bus_if.dout); end
        for (int i = 0; i < 5; i++) begin
            cyc(0, A_STAT, 0, 32'h4198);
            n_tests++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL single_done i%0d got %b exp 0", i, irq); end
        end
    endtask

    task automatic test_rearm();
        cyc(1, A_CTRL, 0, 0);
        cyc(1, A_HOLD, 0, 0);
        cyc(1, A_CTRL, 3, 32'h4198);
        for (int i = 0; i < 12; i++) begin
            cyc(0, A_STAT, 0, 32'h4198);
            n_tests++;
            if (irq !== ((i % 3) == 0)) begin
                n_fail++; $display("FAIL rearm_pat i%0d got %b exp %b", i, irq, (i % 3) == 0);
            end
            n_tests++;
            if (bus_if.dout !== exp_dout(2'd3)) begin
                n_fail++; $display("FAIL rearm_stat i%0d got %h exp %h", i, bus_if.dout, exp_dout(2'd3));
            end
        end
    endtask

    task automatic test_disable_mid();
        cyc(1, A_CTRL, 0, 0);
        cyc(1, A_HOLD, 5, 0);
        cyc(1, A_CTRL, 1, 0);
        cyc(0, A_STAT, 0, 32'h4198);
        cyc(0, A_STAT, 0, 0);
        cyc(0, A_STAT, 0, 0);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL dis_third_high got %b exp 1", irq); end
        cyc(1, A_CTRL, 0, 0);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL dis_drop got %b exp 0", irq); end
        cyc(0, A_STAT, 0, 0);
        n_tests++;
        if (bus_if.dout[1] !== 1'b0) begin n_fail++; $display("FAIL dis_busy got %b exp 0", bus_if.dout[1]); end
        for (int i = 0; i < 8; i++) begin
            cyc(0, A_STAT, 0, 32'h4198);
            n_tests++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL dis_nopulse i%0d got %b exp 0", i, irq); end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, A_HOLD, 5, 0);
        cyc(1, A_CTRL, 1, 0);
        cyc(0, A_STAT, 0, 32'h4198);
        cyc(0, A_STAT, 0, 0);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got %b exp 1", irq); end
        reset = 1'b1;
        cyc(0, A_CTRL, 0, 0);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq got %b exp 0", irq); end
        for (int o = 0; o < 4; o++) begin
            bus_if.addr = 32'(o) << 2;
            #1;
            n_tests++;
            if (bus_if.dout !== 32'h0) begin
                n_fail++; $display("FAIL rstmid_reg%0d got %h exp 0", o, bus_if.dout);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_same_cycle();
        cyc(1, A_TGT, 32'h4198, 0);
        cyc(1, A_HOLD, 1, 0);
        cyc(1, A_CTRL, 1, 32'h4198);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL same_write_wins got %b exp 0", irq); end
        cyc(0, A_STAT, 0, 32'h4198);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL same_next_fires got %b exp 1", irq); end
        cyc(0, A_STAT, 0, 0);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL same_hold1 got %b exp 1", irq); end
        cyc(0, A_STAT, 0, 0);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL same_end got %b exp 0", irq); end
    endtask

    task automatic test_long_hold();
        int runs[$];
        int cur;
        cur = 0;
        cyc(1, A_HOLD, 32'hFF, 0);
        cyc(1, A_CTRL, 3, 32'h4198);
        for (int i = 0; i < 270; i++) begin
            if (i == 100) cyc(1, A_HOLD, 2, 32'h4198);
            else          cyc(0, A_STAT, 0, 32'h4198);
            n_tests++;
            if (irq !== exp_irq()) begin n_fail++; $display("FAIL long_irq i%0d got %b exp %b", i, irq, exp_irq()); end
            if (irq) cur++;
            else if (cur > 0) begin runs.push_back(cur); cur = 0; end
        end
        n_tests++;
        if (runs.size() < 2) begin
            n_fail++; $display("FAIL long_runs got %0d pulses exp 2", runs.size());
        end else begin
            n_tests++;
            if (runs[0] !== 256) begin n_fail++; $display("FAIL long_first got %0d exp 256", runs[0]); end
            if (runs[1] !== 3) begin n_fail++; $display("FAIL long_second got %0d exp 3", runs[1]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] r, a, d, p;
            logic [1:0]  o;
            logic        w;
            r = $urandom();
            o = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 7) == 0);
            case (o)
                2'd0:    d = r;
                2'd1:    d = ($urandom_range(0, 1) != 0) ? 32'h4198 : 32'h41A0;
                2'd2:    d = {r[31:8], 8'($urandom_range(0, 4))};
                default: d = r;
            endcase
            case ($urandom_range(0, 3))
                0, 1:    p = m_target;
                2:       p = 32'h41A0;
                default: p = r;
            endcase
            a = {r[31:4], o, r[1:0]};
            reset = ($urandom_range(0, 149) == 0);
            cyc(w, a, d, p);
            n_tests++;
            if (irq !== exp_irq()) begin n_fail++; $display("FAIL rand_irq i%0d got %b exp %b", i, irq, exp_irq()); end
            n_tests++;
            if (bus_if.dout !== exp_dout(o)) begin
                n_fail++; $display("FAIL rand_dout i%0d off%0d got %h exp %h", i, o, bus_if.dout, exp_dout(o));
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pc = '0;
        bus_if.we = 1'b0;
        bus_if.addr = '0;
        bus_if.din = '0;
        test_reset();
        test_single_shot();
        test_rearm();
        test_disable_mid();
        test_reset_mid();
        test_same_cycle();
        test_long_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_irq_injector.md
# pc_irq_injector

Synthesizable, memory-mapped interrupt source that watches the CPU's macroscopic PC and raises the external interrupt line for a programmable number of cycles when that PC reaches a programmed target. It sits on the bridge as a peripheral next to the timers, and its `irq` output feeds the `interrupt` input of `mips` (CP0 HWInt). It makes the directed "interrupt at PC X, held N cycles" stimulus reproducible on-chip and under software control.

## Interface
- `HOLD_W`, default 8: width of the hold counter. The HOLD register keeps `din[HOLD_W-1:0]`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `pc`  in  32  macroscopic PC of the instruction currently at the commit point.
- `we`  in  1  bridge write strobe for this device.
- `addr`  in  32  bridge byte address. Only `addr[3:2]` is decoded.
- `din`  in  32  write data.
- `dout`  out  32  read data, combinational from `addr[3:2]`.
- `irq`  out  1  interrupt request to the CPU. Registered.

## Operation
- Registers, selected by `addr[3:2]`:
  - 0 CTRL: bit0 EN, bit1 REARM, other bits read 0.
  - 1 TARGET: 32 bits.
  - 2 HOLD: `HOLD_W` bits, zero-extended on read.
  - 3 STATUS: bit0 FIRED, bit1 BUSY.
- STATUS writes: any write to offset 3 clears FIRED and is otherwise ignored.
- States:
  - IDLE: EN=0.
  - ARMED: waiting for a match.
  - ASSERT: `irq`=1, counting down.
  - GAP: one cycle with `irq`=0 before re-arming.
  - DONE: fired; not re-armed.
- Transitions, evaluated each rising edge:
  - IDLE→ARMED when EN=1.
  - ARMED→ASSERT when `pc`==TARGET. The counter loads HOLD and FIRED is set.
  - ASSERT: counter decrements. When counter==0, go to GAP if REARM=1, else DONE.
  - GAP→ARMED.
  - DONE stays in DONE until CTRL is written.
- A CTRL write from any state goes to ARMED if the new EN=1, else IDLE. The counter clears and `irq` drops on the next edge.
- EN=0 forces IDLE in every state, via CTRL write.
- While in ASSERT/GAP/DONE, a match is ignored. No pending match is queued.
- Same-cycle CTRL write and match: the write wins and the match is discarded.
- TARGET/HOLD writes during ASSERT do not affect the running counter; they take effect at the next trigger.
- BUSY = (state==ASSERT || state==GAP).
- HOLD=0 gives a 1-cycle pulse. HOLD=2^HOLD_W−1 gives 2^HOLD_W cycles. The counter must not wrap below 0.

## Timing
- Reset: CTRL, TARGET, HOLD, STATUS, counter = 0; state = IDLE; `irq` = 0.
- Reset mid-ASSERT drops `irq` on that same edge.
- Match seen on edge t → `irq`=1 from edge t through edge t+HOLD. That is exactly HOLD+1 cycles high, then low after edge t+HOLD+1.
- With REARM=1:
  - One guaranteed low cycle (GAP).
  - Earliest next rising edge of `irq` is t+HOLD+3, if `pc` still equals TARGET.
- A register write on edge t is visible on `dout` from edge t onward, same cycle after the edge.
- FIRED is readable starting the cycle `irq` first goes high.
- `dout` is 0 for no offset; all four offsets are decoded.

## Structure
- Shared package or header:
  - register offset constants: CTRL=0, TARGET=1, HOLD=2, STATUS=3;
  - CTRL bit positions: EN=0, REARM=1;
  - STATUS bit positions: FIRED=0, BUSY=1;
  - state encodings for IDLE/ARMED/ASSERT/GAP/DONE.
- Single module with no sub-module. The bridge decodes the device base address and supplies `we` only for this device's range.

## Test plan
- Reset, then TARGET=0x00004198, HOLD=5, CTRL=0x1; drive `pc`=0x4198 once → `irq` high exactly 6 cycles starting the match edge, STATUS=0x1, then state DONE, with no second pulse when `pc` returns to 0x4198.
- Same setup with CTRL=0x3, HOLD=0, `pc` held at 0x4198 → `irq` toggles as 1 high, 2 low (GAP + ARMED match), repeatedly.
- During ASSERT with HOLD=5, write CTRL=0x0 at the 3rd high cycle → `irq` low on the next edge, BUSY=0, and a later match at 0x4198 produces no pulse.
- Assert `reset` during ASSERT → `irq`=0 and all register reads return 0 on the following cycle.
- Same-cycle CTRL=0x1 write and `pc`==TARGET → no pulse that cycle; the next cycle's match fires.
- HOLD=0xFF with `HOLD_W`=8 → exactly 256 high cycles; write HOLD=2 mid-pulse → current pulse length unchanged, next pulse lasts 3 cycles.
